// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per enabled cycle, done after DIVIDEND_W iterations (divide-by-zero: 1 cycle).
// start is taken only in IDLE; enable=0 freezes everything. Optional check_err output under `DIV_SELFCHECK_EN`.
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
`ifdef DIV_SELFCHECK_EN
  ,
  output logic                  check_err
`endif
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  // dvd_q shifts the dividend out MSB-first while quotient bits enter at the LSB
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W:0]    prem_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DIVISOR_W+1:0]  shifted;
  logic [DIVISOR_W+1:0]  trial;
  logic                  qbit;
  logic [DIVISOR_W:0]    prem_nxt;
  logic [DIVIDEND_W-1:0] quo_nxt;

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Trial subtraction; the top bit of trial is the borrow
  always_comb begin
    shifted  = {prem_q, dvd_q[DIVIDEND_W-1]};
    trial    = shifted - {2'b00, dvs_q};
    qbit     = ~trial[DIVISOR_W+1];
    prem_nxt = qbit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    quo_nxt  = {dvd_q[DIVIDEND_W-2:0], qbit};
  end

`ifdef DIV_SELFCHECK_EN
  localparam int P_W = DIVIDEND_W + DIVISOR_W + 1;
  logic [DIVIDEND_W-1:0] dvd_cap;
  logic                  chk_bad;
  assign chk_bad = (P_W'(quo_nxt) * P_W'(dvs_q) + P_W'(prem_nxt)) != P_W'(dvd_cap);
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
`ifdef DIV_SELFCHECK_EN
      dvd_cap     <= '0;
      check_err   <= 1'b0;
`endif
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
`ifdef DIV_SELFCHECK_EN
              check_err   <= 1'b0;
`endif
            end else begin
              dvd_q  <= dividend;
              dvs_q  <= divisor;
              prem_q <= '0;
              cnt_q  <= CNT_W'(DIVIDEND_W - 1);
`ifdef DIV_SELFCHECK_EN
              dvd_cap <= dividend;
`endif
            end
          end
        end
        CALC: begin
          dvd_q  <= quo_nxt;
          prem_q <= prem_nxt;
          if (cnt_q == '0) begin
            quotient    <= quo_nxt;
            remainder   <= prem_nxt[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
`ifdef DIV_SELFCHECK_EN
            check_err   <= chk_bad;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: fixed vector table, hand-written enable/reset/ignored-start sequences, random ops vs. a / and % model.
module tb_seq_divider;

  logic       clock;
  logic       rst;
  logic       enable;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
`ifdef DIV_SELFCHECK_EN
  logic       check_err;
`endif

  seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clock       (clock),
    .rst         (rst),
    .enable      (enable),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
`ifdef DIV_SELFCHECK_EN
    ,
    .check_err   (check_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_q = '0;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void ref_div(input int a, input int b,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic z, output int lat);
    if (b == 0) begin
      q = 8'hFF; r = 4'(a % 16); z = 1'b1; lat = 0;
    end else begin
      q = 8'(a / b); r = 4'(a % b); z = 1'b0; lat = 8;
    end
  endfunction

  // Starts one operation in IDLE, waits for done, checks results and the single-cycle done pulse.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er, input logic ez, input int elat);
    int n;
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    check({tag, " busy"}, 32'(busy), 32'(1));
    if (elat > 0) check({tag, " hold_q"}, 32'(quotient), 32'(last_q));
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(elat));
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
`ifdef DIV_SELFCHECK_EN
    check({tag, " check_err"}, 32'(check_err), 32'(0));
`endif
    last_q = eq;
    tick();
    check({tag, " pulse"}, 32'({done, busy}), 32'(0));
  endtask

  initial begin
    int n;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    int         elat;

    tbl[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 8};
    tbl[1]  = '{8'hFF,  4'd1,  8'd255, 4'd0,  1'b0, 8};
    tbl[2]  = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0, 8};
    tbl[3]  = '{8'h5A,  4'd0,  8'hFF,  4'hA,  1'b1, 0};
    tbl[4]  = '{8'd9,   4'd3,  8'd3,   4'd0,  1'b0, 8};
    tbl[5]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 8};
    tbl[6]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8};
    tbl[7]  = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 8};
    tbl[8]  = '{8'd128, 4'd0,  8'hFF,  4'd0,  1'b1, 0};
    tbl[9]  = '{8'd7,   4'd7,  8'd1,   4'd0,  1'b0, 8};
    tbl[10] = '{8'd1,   4'd15, 8'd0,   4'd1,  1'b0, 8};

    rst = 1'b1; enable = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    check("reset outputs", 32'({quotient, remainder, busy, done, div_by_zero}), 32'(0));
    rst = 1'b0;
    tick();

    // Back-to-back: each new start goes in on the first cycle after done
    foreach (tbl[i]) run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].lat);

    // Freeze for 5 cycles mid-calculation, then hold done with enable low
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    enable = 1'b0;
    repeat (5) tick();
    check("freeze busy", 32'({busy, done}), 32'(2'b10));
    enable = 1'b1;
    n = 8;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check("freeze latency", 32'(n), 32'(13));
    check("freeze result", 32'({quotient, remainder}), 32'({8'd28, 4'd4}));
    enable = 1'b0;
    repeat (3) tick();
    check("done stretched", 32'(done), 32'(1));
    enable = 1'b1;
    tick();
    check("done after stretch", 32'(done), 32'(0));

    // Reset during the calculation aborts it
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort outputs", 32'({quotient, remainder, busy, done, div_by_zero}), 32'(0));
    n = 0;
    repeat (12) begin
      tick();
      if (done) n++;
    end
    check("abort no done", 32'(n), 32'(0));
    last_q = '0;

    // A start arriving during CALC is dropped
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    tick();
    start = 1'b0;
    n = 3;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("ignore latency", 32'(n), 32'(8));
    check("ignore result", 32'({quotient, remainder, div_by_zero}), 32'({8'd33, 4'd1, 1'b0}));
    last_q = 8'd33;
    tick();

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom);
      b = 4'($urandom_range(0, 15));
      ref_div(int'(a), int'(b), eq, er, ez, elat);
      run_op($sformatf("rnd%0d %0d/%0d", i, a, b), a, b, eq, er, ez, elat);
    end

`ifdef DIV_SELFCHECK_EN
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        ref_div(a, b, eq, er, ez, elat);
        run_op($sformatf("sweep %0d/%0d", a, b), 8'(a), 4'(b), eq, er, ez, elat);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
